// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with STEP shifts per enabled cycle, zero-seed
// protection, a saturating shift counter and a period-wrap pulse.
module lfsr_gen #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(64'hD800_0000_0000_0000),
    parameter int               STEP       = 1,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
    parameter int               CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step_en,
    output logic [WIDTH-1:0] shift_seed,
    output logic [STEP-1:0]  rand_bits,
    output logic [CNT_W-1:0] step_cnt,
    output logic             wrap,
    output logic             seed_fixed
);

    // Extra headroom bits so STEP can exceed the counter range without aliasing.
    localparam int SUM_W = CNT_W + $clog2(STEP + 1) + 1;

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed_ref;
    logic [STEP-1:0]  r_rand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic             r_fixed;

    logic [WIDTH-1:0] w_next;
    logic [STEP-1:0]  w_fb_bits;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_seed_zero;

    // Unrolled shift chain; the first shift's feedback bit lands in the MSB.
    always_comb begin
        logic v_fb;
        w_next    = r_state;
        w_fb_bits = '0;
        for (int k = 0; k < STEP; k++) begin
            v_fb                 = ^(w_next & TAPS);
            w_next               = {w_next[WIDTH-2:0], v_fb};
            w_fb_bits[STEP-1-k]  = v_fb;
        end
    end

    always_comb begin
        w_sum = {{(SUM_W-CNT_W){1'b0}}, r_cnt} + SUM_W'(STEP);
        if (r_wrap)
            w_cnt_next = '0;
        else if (|w_sum[SUM_W-1:CNT_W])
            w_cnt_next = '1;
        else
            w_cnt_next = w_sum[CNT_W-1:0];
    end

    assign w_seed_zero = (seed == '0);
    assign w_load_val  = w_seed_zero ? WIDTH'(1) : seed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RESET_SEED;
            r_seed_ref <= RESET_SEED;
            r_rand     <= '0;
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
            r_fixed    <= 1'b0;
        end else if (seed_load) begin
            r_state    <= w_load_val;
            r_seed_ref <= w_load_val;
            r_rand     <= '0;
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
            r_fixed    <= w_seed_zero;
        end else if (step_en) begin
            r_state    <= w_next;
            r_rand     <= w_fb_bits;
            r_cnt      <= w_cnt_next;
            r_wrap     <= (w_next == r_seed_ref);
            r_fixed    <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_fixed    <= 1'b0;
        end
    end

    assign shift_seed = r_state;
    assign rand_bits  = r_rand;
    assign step_cnt   = r_cnt;
    assign wrap       = r_wrap;
    assign seed_fixed = r_fixed;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 4-bit sequences, seed handling, STEP=3,
// 64-bit reference run with asynchronous reset, and counter saturation.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // a: WIDTH=4 STEP=1
    logic        a_load, a_step;
    logic [3:0]  a_seed, a_state;
    logic [0:0]  a_rand;
    logic [31:0] a_cnt;
    logic        a_wrap, a_fixed;
    // b: WIDTH=4 STEP=3
    logic        b_load, b_step;
    logic [3:0]  b_seed, b_state;
    logic [2:0]  b_rand;
    logic [31:0] b_cnt;
    logic        b_wrap, b_fixed;
    // c: default 64-bit
    logic        c_load, c_step;
    logic [63:0] c_seed, c_state;
    logic [0:0]  c_rand;
    logic [31:0] c_cnt;
    logic        c_wrap, c_fixed;
    // d: WIDTH=8 CNT_W=4
    logic        d_load, d_step;
    logic [7:0]  d_seed, d_state;
    logic [0:0]  d_rand;
    logic [3:0]  d_cnt;
    logic        d_wrap, d_fixed;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .STEP(1), .RESET_SEED(4'h1), .CNT_W(32)) u_a (
        .clk(clk), .reset(reset), .seed_load(a_load), .seed(a_seed), .step_en(a_step),
        .shift_seed(a_state), .rand_bits(a_rand), .step_cnt(a_cnt), .wrap(a_wrap),
        .seed_fixed(a_fixed));

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .STEP(3), .RESET_SEED(4'h1), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .seed_load(b_load), .seed(b_seed), .step_en(b_step),
        .shift_seed(b_state), .rand_bits(b_rand), .step_cnt(b_cnt), .wrap(b_wrap),
        .seed_fixed(b_fixed));

    lfsr_gen u_c (
        .clk(clk), .reset(reset), .seed_load(c_load), .seed(c_seed), .step_en(c_step),
        .shift_seed(c_state), .rand_bits(c_rand), .step_cnt(c_cnt), .wrap(c_wrap),
        .seed_fixed(c_fixed));

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .STEP(1), .RESET_SEED(8'h1), .CNT_W(4)) u_d (
        .clk(clk), .reset(reset), .seed_load(d_load), .seed(d_seed), .step_en(d_step),
        .shift_seed(d_state), .rand_bits(d_rand), .step_cnt(d_cnt), .wrap(d_wrap),
        .seed_fixed(d_fixed));

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] ref64_next(input logic [63:0] s);
        return {s[62:0], ^(s & 64'hD800_0000_0000_0000)};
    endfunction

    logic [3:0] seq_from1 [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                   4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] seq_from9 [15] = '{4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF,
                                   4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9};
    logic [3:0] seq_step3 [5]  = '{4'h9, 4'hD, 4'hB, 4'hE, 4'h1};

    initial begin
        logic [63:0] exp;
        logic [63:0] model;
        int wraps;

        reset = 1'b1;
        a_load = 0; a_step = 0; a_seed = '0;
        b_load = 0; b_step = 0; b_seed = '0;
        c_load = 0; c_step = 0; c_seed = '0;
        d_load = 0; d_step = 0; d_seed = '0;
        #2;
        do_reset();

        // Reset state
        check("a_rst_state", a_state, 4'h1);
        check("a_rst_rand", a_rand, 0);
        check("a_rst_cnt", a_cnt, 0);
        check("a_rst_wrap", a_wrap, 0);
        check("a_rst_fixed", a_fixed, 0);

        // Full period from reset seed
        for (int i = 0; i < 15; i++) exp_q.push_back(64'(seq_from1[i]));
        a_step = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp = exp_q.pop_front();
            check("a_seq_state", a_state, exp);
            check("a_seq_cnt", a_cnt, 64'(i + 1));
            check("a_seq_wrap", a_wrap, 64'(i == 14));
        end
        tick();
        check("a_after_wrap_state", a_state, 4'h2);
        check("a_after_wrap_pulse", a_wrap, 0);
        check("a_after_wrap_cnt", a_cnt, 0);
        a_step = 0;

        // Zero seed replaced by 1
        a_seed = 4'h0; a_load = 1;
        tick();
        check("a_zero_state", a_state, 4'h1);
        check("a_zero_fixed", a_fixed, 1);
        check("a_zero_cnt", a_cnt, 0);
        a_load = 0;
        tick();
        check("a_zero_fixed_drop", a_fixed, 0);
        check("a_zero_hold", a_state, 4'h1);

        // Load 9 and run a full period back to 9
        a_seed = 4'h9; a_load = 1;
        tick();
        check("a_load9_state", a_state, 4'h9);
        check("a_load9_fixed", a_fixed, 0);
        check("a_load9_rand", a_rand, 0);
        a_load = 0; a_step = 1;
        wraps = 0;
        for (int i = 0; i < 15; i++) exp_q.push_back(64'(seq_from9[i]));
        for (int i = 0; i < 15; i++) begin
            tick();
            exp = exp_q.pop_front();
            check("a_seq9_state", a_state, exp);
            if (a_wrap) wraps++;
        end
        check("a_seq9_wrap_now", a_wrap, 1);
        check("a_seq9_wraps", 64'(wraps), 1);
        a_step = 0;

        // Load and step together: load wins
        a_seed = 4'h5; a_load = 1; a_step = 1;
        tick();
        check("a_ldstep_state", a_state, 4'h5);
        check("a_ldstep_cnt", a_cnt, 0);
        a_load = 0;
        tick();
        check("a_ldstep_next", a_state, 4'hB);
        check("a_ldstep_rand", a_rand, 1);
        check("a_ldstep_cnt1", a_cnt, 1);
        a_step = 0;

        // STEP=3 instance
        do_reset();
        b_step = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_state", b_state, 64'(seq_step3[i]));
            check("b_cnt", b_cnt, 64'(3 * (i + 1)));
            check("b_wrap", b_wrap, 64'(i == 4));
            if (i == 0) check("b_rand_first", b_rand, 3'b001);
        end
        b_step = 0;

        // 64-bit default against reference model
        do_reset();
        check("c_rst_state", c_state, 64'h1);
        model = 64'h1;
        c_step = 1;
        for (int i = 0; i < 10000; i++) begin
            model = ref64_next(model);
            if (i == 9999) begin
                a_seed = 4'h0; a_load = 1;
            end
            tick();
            check("c_state", c_state, model);
            check("c_rand", c_rand, 64'(model[0]));
            if (i == 63) check("c_state_64", c_state, 64'h1B);
        end
        check("c_cnt", c_cnt, 10000);
        check("c_wrap", c_wrap, 0);
        check("a_fixed_pulse", a_fixed, 1);
        a_load = 0;

        // Asynchronous reset mid-run and mid-pulse
        reset = 1'b1;
        #1;
        check("c_arst_state", c_state, 64'h1);
        check("c_arst_rand", c_rand, 0);
        check("c_arst_cnt", c_cnt, 0);
        check("c_arst_wrap", c_wrap, 0);
        check("c_arst_fixed", c_fixed, 0);
        check("a_arst_fixed", a_fixed, 0);
        c_step = 0;
        tick();
        reset = 1'b0;
        tick();
        check("c_post_rst_state", c_state, 64'h1);

        // Counter saturation on narrow counter
        do_reset();
        d_step = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("d_cnt", d_cnt, 64'((i + 1 > 15) ? 15 : i + 1));
            check("d_wrap", d_wrap, 0);
            if (i == 2) check("d_state3", d_state, 8'h08);
        end
        d_step = 0;
        tick();
        check("d_cnt_hold", d_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
